// File: rtl/serial_sub.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to compute signed overflow; otherwise ovf is tied to 0.
module serial_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_rs;
   logic             r_brw;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_d;
   logic             r_bout;

   logic             w_x;
   logic             w_y;
   logic             w_diff;
   logic             w_brw_next;
   logic             w_last;
   logic [WIDTH-1:0] w_rs_next;

   // Full-subtractor slice on the current LSBs.
   assign w_x        = r_sa[0];
   assign w_y        = r_sb[0];
   assign w_diff     = w_x ^ w_y ^ r_brw;
   assign w_brw_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_brw);
   assign w_rs_next  = {w_diff, r_rs[WIDTH-1:1]};
   assign w_last     = (r_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = SHIFT;
         SHIFT:   if (w_last) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != IDLE);
      done = (r_state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sa   <= '0;
         r_sb   <= '0;
         r_rs   <= '0;
         r_brw  <= 1'b0;
         r_cnt  <= '0;
         r_d    <= '0;
         r_bout <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_sa  <= a;
                  r_sb  <= b;
                  r_brw <= bin;
                  r_cnt <= '0;
               end
            end
            SHIFT: begin
               r_sa  <= r_sa >> 1;
               r_sb  <= r_sb >> 1;
               r_rs  <= w_rs_next;
               r_brw <= w_brw_next;
               if (w_last) begin
                  r_d    <= w_rs_next;
                  r_bout <= w_brw_next;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign d    = r_d;
   assign bout = r_bout;

`ifdef SERIAL_SUB_OVF_EN
   logic r_ovf;

   // Overflow = borrow into the MSB slice differs from borrow out of it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (r_state == SHIFT && w_last) begin
         r_ovf <= r_brw ^ w_brw_next;
      end
   end

   assign ovf = r_ovf;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (WIDTH=8).
`timescale 1ns/1ps
module tb_serial_sub;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] d;
   logic         bout;
   logic         ovf;

   int checks = 0;
   int errors = 0;

   serial_sub #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .d     (d),
      .bout  (bout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic ovf_exp(input logic v);
`ifdef SERIAL_SUB_OVF_EN
      return v;
`else
      return 1'b0 & v;
`endif
   endfunction

   // Waits for done after the accepting edge; checks latency and that d holds meanwhile.
   task automatic wait_done(input string name, input logic [W-1:0] prev_d,
                            input int exp_lat);
      int lat = 1;
      while (done !== 1'b1 && lat <= 20) begin
         checks++;
         if (d !== prev_d || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s hold: d=%h busy=%b required d=%h busy=1", name, d, busy, prev_d);
         end
         tick();
         lat++;
      end
      lat--;
      checks++;
      if (lat !== exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
      end
   endtask

   task automatic check_result(input string name, input logic [W-1:0] ed,
                               input logic eb, input logic eo);
      checks++;
      if (d !== ed || bout !== eb || ovf !== eo || done !== 1'b1) begin
         errors++;
         $display("FAIL %s: d=%h bout=%b ovf=%b done=%b required d=%h bout=%b ovf=%b done=1",
                  name, d, bout, ovf, done, ed, eb, eo);
      end
      $display("%s: d=%h bout=%b ovf=%b", name, d, bout, ovf);
   endtask

   task automatic run_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ibin, input logic [W-1:0] ed, input logic eb,
                         input logic eo);
      logic [W-1:0] prev_d;
      prev_d = d;
      a = ia; b = ib; bin = ibin; start = 1'b1;
      tick();
      start = 1'b0;
      a = '0; b = '0; bin = 1'b0;
      wait_done(name, prev_d, W);
      check_result(name, ed, eb, ovf_exp(eo));
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s idle: busy=%b done=%b required 0 0", name, busy, done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h11; bin = 1'b1;
      tick(); tick();
      rst = 1'b0; start = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || d !== 8'h00 || bout !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b d=%h bout=%b ovf=%b required all 0",
                  busy, done, d, bout, ovf);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_start_dropped: busy=%b required 0", busy);
      end
   endtask

   task automatic test_arith();
      run_op("sub_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
      run_op("sub_03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
      run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      run_op("sub_00_00_bin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
   endtask

   task automatic test_start_ignored();
      logic [W-1:0] prev_d;
      prev_d = d;
      a = 8'h40; b = 8'h20; bin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      a = 8'h01; b = 8'h02; bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (d !== prev_d) begin
         errors++;
         $display("FAIL ignore_hold: d=%h required %h", d, prev_d);
      end
      wait_done("ignore_start", prev_d, W - 3);
      check_result("ignore_start", 8'h1F, 1'b0, ovf_exp(1'b0));
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore_idle: busy=%b required 0", busy);
      end
   endtask

   task automatic test_mid_reset();
      a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || d !== 8'h00 || bout !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: busy=%b done=%b d=%h bout=%b ovf=%b required all 0",
                  busy, done, d, bout, ovf);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_quiet: done=%b busy=%b at cycle %0d required 0 0",
                     done, busy, i);
         end
      end
      run_op("after_reset_10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] prev_d;
      prev_d = d;
      a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
      tick();
      wait_done("b2b_first", prev_d, W);
      check_result("b2b_first", 8'h02, 1'b0, ovf_exp(1'b0));
      a = 8'h7F; b = 8'hFF; bin = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_gap: busy=%b done=%b required 0 0", busy, done);
      end
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept: busy=%b required 1", busy);
      end
      prev_d = d;
      wait_done("b2b_second", prev_d, W);
      check_result("b2b_second", 8'h80, 1'b1, ovf_exp(1'b1));
      tick();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      test_reset();
      test_arith();
      test_start_ignored();
      test_mid_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
